// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, FSM state type and write-beat record for the register file write arbiter.
// The register file is 32 entries of 32 bits, addressed by a 5-bit index.
package regwr_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(NREG - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One registered beat on the register file write port.
    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wrBeat_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshake, clear control and register file write port, bundled as one interface.
// The slave modport is the arbiter's view; master is the view of whatever drives the requests.
interface regfile_write_arbiter_if
    import regwr_pkg::*;
#(
    parameter int NREQ = 3
);

    logic [NREQ-1:0]        ReqValid;
    logic [NREQ-1:0]        ReqReady;
    logic [NREQ*ADDR_W-1:0] ReqAddr;
    logic [NREQ*DATA_W-1:0] ReqData;
    logic                   ClearStart;
    logic                   Busy;
    logic                   ClearDone;
    logic [DATA_W-1:0]      WrData;
    logic [ADDR_W-1:0]      WrAddr;
    logic                   WrEn;

    modport master (
        output ReqValid, ReqAddr, ReqData, ClearStart,
        input  ReqReady, Busy, ClearDone, WrData, WrAddr, WrEn
    );

    modport slave (
        input  ReqValid, ReqAddr, ReqData, ClearStart,
        output ReqReady, Busy, ClearDone, WrData, WrAddr, WrEn
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo N.
// ptr is assumed to stay below N.
module rr_arbiter #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grantIdx
);

    logic         found;
    logic [W:0]   sum;
    logic [W-1:0] idx;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit keeps ptr+i exact before the modulo-N fold.
            sum = {1'b0, ptr} + (W+1)'(i);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            idx = sum[W-1:0];
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grantIdx    = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter and clear sequencer in front of the 32x32 register file write port.
// Write port outputs are registered: a handshake in one cycle drives the register file the next.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | grant at most one requester per cycle, round-robin from rrPtr
//  CLEAR | write zero to addresses 0..31, one per cycle, requests stalled
module regfile_write_arbiter
    import regwr_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter bit PROTECT_R0 = 1'b1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    regfile_write_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NREQ);

    state_t            state;
    state_t            stateNxt;
    logic [ADDR_W-1:0] clearCnt;
    logic [ADDR_W-1:0] clearCntNxt;
    logic [PTR_W-1:0]  rrPtr;
    logic [PTR_W-1:0]  rrPtrNxt;
    logic              clearDoneQ;
    logic              clearDoneNxt;
    wrBeat_t           wrQ;
    wrBeat_t           wrNxt;

    logic [NREQ-1:0]   grant;
    logic [PTR_W-1:0]  grantIdx;
    logic [NREQ-1:0]   reqReady;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    rr_arbiter #(
        .N (NREQ),
        .W (PTR_W)
    ) uArb (
        .req      (bus.ReqValid),
        .ptr      (rrPtr),
        .grant    (grant),
        .grantIdx (grantIdx)
    );

    // The grant is one-hot, so an OR of masked fields is the selected requester's fields.
    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                selAddr = selAddr | bus.ReqAddr[i*ADDR_W +: ADDR_W];
                selData = selData | bus.ReqData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE: begin
                if (bus.ClearStart) begin
                    stateNxt = CLEAR;
                end
            end
            CLEAR: begin
                if (clearCnt == CLEAR_LAST) begin
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    // Computes the next registered write beat; in CLEAR the registered address always equals clearCnt.
    always_comb begin
        wrNxt        = wrQ;
        wrNxt.en     = 1'b0;
        clearCntNxt  = clearCnt;
        rrPtrNxt     = rrPtr;
        clearDoneNxt = 1'b0;
        reqReady     = '0;
        unique case (state)
            IDLE: begin
                if (bus.ClearStart) begin
                    clearCntNxt = '0;
                    wrNxt.en    = 1'b1;
                    wrNxt.addr  = '0;
                    wrNxt.data  = '0;
                end else if (|grant) begin
                    reqReady   = grant;
                    wrNxt.en   = !(PROTECT_R0 && (selAddr == '0));
                    wrNxt.addr = selAddr;
                    wrNxt.data = selData;
                    rrPtrNxt   = (grantIdx == PTR_W'(NREQ - 1)) ? '0 : grantIdx + PTR_W'(1);
                end
            end
            CLEAR: begin
                wrNxt.data = '0;
                if (clearCnt == CLEAR_LAST) begin
                    clearCntNxt  = '0;
                    clearDoneNxt = 1'b1;
                end else begin
                    clearCntNxt = clearCnt + ADDR_W'(1);
                    wrNxt.en    = 1'b1;
                    wrNxt.addr  = clearCnt + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clearCnt   <= '0;
            rrPtr      <= '0;
            clearDoneQ <= 1'b0;
            wrQ        <= '0;
        end else begin
            clearCnt   <= clearCntNxt;
            rrPtr      <= rrPtrNxt;
            clearDoneQ <= clearDoneNxt;
            wrQ        <= wrNxt;
        end
    end

    assign bus.ReqReady  = Reset ? reqReady : '0;
    assign bus.Busy      = (state == CLEAR);
    assign bus.ClearDone = clearDoneQ;
    assign bus.WrEn      = wrQ.en;
    assign bus.WrAddr    = wrQ.addr;
    assign bus.WrData    = wrQ.data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with NREQ=3, PROTECT_R0=1 and a behavioural register file.
module tb_regfile_write_arbiter;

    logic Clock;
    logic rstN;
    int   checks;
    int   errors;
    int   expPtr;
    logic [31:0] rf [32];

    regfile_write_arbiter_if #(.NREQ(3)) bus ();

    regfile_write_arbiter #(
        .NREQ       (3),
        .PROTECT_R0 (1'b1)
    ) dut (
        .Clock (Clock),
        .Reset (rstN),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always_ff @(posedge Clock) begin
        if (bus.WrEn) rf[bus.WrAddr] <= bus.WrData;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic setReq(input int i, input logic [4:0] addr, input logic [31:0] data);
        bus.ReqAddr[i*5 +: 5]   = addr;
        bus.ReqData[i*32 +: 32] = data;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        bus.ReqValid = 3'b111;
        bus.ClearStart = 1'b0;
        bus.ReqAddr = '0;
        bus.ReqData = '0;
        tick();
        #2;
        checks++;
        if (bus.ReqReady !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready_low: ReqReady=%b expected 000", bus.ReqReady);
        end
        tick();
        bus.ReqValid = 3'b000;
        rstN = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            #2;
            checks++;
            if (bus.WrEn !== 1'b0 || bus.WrAddr !== 5'd0 || bus.WrData !== 32'd0 ||
                bus.ReqReady !== 3'b000 || bus.Busy !== 1'b0 || bus.ClearDone !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle c%0d: WrEn=%b WrAddr=%0d WrData=%h ReqReady=%b Busy=%b ClearDone=%b expected all zero",
                         c, bus.WrEn, bus.WrAddr, bus.WrData, bus.ReqReady, bus.Busy, bus.ClearDone);
            end
        end
        expPtr = 0;
    endtask

    task automatic test_single();
        tick();
        setReq(0, 5'd5, 32'hDEADBEEF);
        bus.ReqValid = 3'b001;
        #2;
        checks++;
        if (bus.ReqReady !== 3'b001) begin
            errors++;
            $display("FAIL single_ready: ReqReady=%b expected 001", bus.ReqReady);
        end
        tick();
        bus.ReqValid = 3'b000;
        #2;
        checks++;
        if (bus.WrEn !== 1'b1 || bus.WrAddr !== 5'd5 || bus.WrData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write: WrEn=%b WrAddr=%0d WrData=%h expected 1/5/deadbeef",
                     bus.WrEn, bus.WrAddr, bus.WrData);
        end
        tick();
        #2;
        checks++;
        if (rf[5] !== 32'hDEADBEEF || bus.WrEn !== 1'b0) begin
            errors++;
            $display("FAIL single_readback: rf[5]=%h WrEn=%b expected deadbeef/0", rf[5], bus.WrEn);
        end
        expPtr = 1;
    endtask

    task automatic test_round_robin();
        logic [2:0]  expReady;
        logic [4:0]  prevAddr;
        logic [31:0] prevData;
        int g;
        prevAddr = '0;
        prevData = '0;
        setReq(0, 5'd1, 32'h0000_00A0);
        setReq(1, 5'd2, 32'h0000_00A1);
        setReq(2, 5'd3, 32'h0000_00A2);
        for (int c = 0; c < 7; c++) begin
            tick();
            bus.ReqValid = (c < 6) ? 3'b111 : 3'b000;
            #2;
            if (c > 0) begin
                checks++;
                if (bus.WrEn !== 1'b1 || bus.WrAddr !== prevAddr || bus.WrData !== prevData) begin
                    errors++;
                    $display("FAIL rr_write c%0d: WrEn=%b WrAddr=%0d WrData=%h expected 1/%0d/%h",
                             c, bus.WrEn, bus.WrAddr, bus.WrData, prevAddr, prevData);
                end
            end
            if (c < 6) begin
                g = expPtr;
                expReady = 3'b001 << g;
                checks++;
                if (bus.ReqReady !== expReady) begin
                    errors++;
                    $display("FAIL rr_grant c%0d: ReqReady=%b expected %b", c, bus.ReqReady, expReady);
                end
                prevAddr = 5'(g + 1);
                prevData = 32'h0000_00A0 + 32'(g);
                expPtr = (g + 1) % 3;
            end
        end
    endtask

    task automatic test_clear_with_req();
        tick();
        setReq(2, 5'd9, 32'hCAFEF00D);
        bus.ReqValid = 3'b100;
        bus.ClearStart = 1'b1;
        #2;
        checks++;
        if (bus.ReqReady !== 3'b000 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_start: ReqReady=%b Busy=%b expected 000/0", bus.ReqReady, bus.Busy);
        end
        for (int k = 0; k < 32; k++) begin
            tick();
            bus.ClearStart = (k == 5);
            #2;
            checks++;
            if (bus.Busy !== 1'b1 || bus.WrEn !== 1'b1 || bus.WrAddr !== 5'(k) || bus.WrData !== 32'd0 ||
                bus.ReqReady !== 3'b000 || bus.ClearDone !== 1'b0) begin
                errors++;
                $display("FAIL clear_beat k%0d: Busy=%b WrEn=%b WrAddr=%0d WrData=%h ReqReady=%b ClearDone=%b expected 1/1/%0d/0/000/0",
                         k, bus.Busy, bus.WrEn, bus.WrAddr, bus.WrData, bus.ReqReady, bus.ClearDone, k);
            end
        end
        tick();
        bus.ClearStart = 1'b0;
        #2;
        checks++;
        if (bus.ClearDone !== 1'b1 || bus.Busy !== 1'b0 || bus.ReqReady !== 3'b100 || bus.WrEn !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: ClearDone=%b Busy=%b ReqReady=%b WrEn=%b expected 1/0/100/0",
                     bus.ClearDone, bus.Busy, bus.ReqReady, bus.WrEn);
        end
        expPtr = 0;
        tick();
        bus.ReqValid = 3'b000;
        #2;
        checks++;
        if (bus.ClearDone !== 1'b0 || bus.WrEn !== 1'b1 || bus.WrAddr !== 5'd9 || bus.WrData !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL clear_after_write: ClearDone=%b WrEn=%b WrAddr=%0d WrData=%h expected 0/1/9/cafef00d",
                     bus.ClearDone, bus.WrEn, bus.WrAddr, bus.WrData);
        end
        tick();
        #2;
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (rf[r] !== ((r == 9) ? 32'hCAFEF00D : 32'd0)) begin
                errors++;
                $display("FAIL clear_contents r%0d: rf=%h expected %h", r, rf[r],
                         (r == 9) ? 32'hCAFEF00D : 32'd0);
            end
        end
    endtask

    task automatic test_protect_r0();
        tick();
        setReq(1, 5'd0, 32'h0000_1234);
        bus.ReqValid = 3'b010;
        #2;
        checks++;
        if (bus.ReqReady !== 3'b010) begin
            errors++;
            $display("FAIL r0_ready: ReqReady=%b expected 010", bus.ReqReady);
        end
        tick();
        bus.ReqValid = 3'b000;
        #2;
        checks++;
        if (bus.WrEn !== 1'b0) begin
            errors++;
            $display("FAIL r0_wren: WrEn=%b expected 0", bus.WrEn);
        end
        tick();
        #2;
        checks++;
        if (rf[0] !== 32'd0) begin
            errors++;
            $display("FAIL r0_unchanged: rf[0]=%h expected 0", rf[0]);
        end
        expPtr = 2;
    endtask

    task automatic test_reset_mid_clear();
        tick();
        bus.ClearStart = 1'b1;
        tick();
        bus.ClearStart = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        #2;
        checks++;
        if (bus.Busy !== 1'b1 || bus.WrAddr !== 5'd10) begin
            errors++;
            $display("FAIL midclear_beat: Busy=%b WrAddr=%0d expected 1/10", bus.Busy, bus.WrAddr);
        end
        rstN = 1'b0;
        bus.ReqValid = 3'b010;
        #1;
        checks++;
        if (bus.WrEn !== 1'b0 || bus.WrAddr !== 5'd0 || bus.WrData !== 32'd0 || bus.Busy !== 1'b0 ||
            bus.ClearDone !== 1'b0 || bus.ReqReady !== 3'b000) begin
            errors++;
            $display("FAIL midclear_reset: WrEn=%b WrAddr=%0d WrData=%h Busy=%b ClearDone=%b ReqReady=%b expected all zero",
                     bus.WrEn, bus.WrAddr, bus.WrData, bus.Busy, bus.ClearDone, bus.ReqReady);
        end
        tick();
        tick();
        bus.ReqValid = 3'b000;
        rstN = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            #2;
            checks++;
            if (bus.ClearDone !== 1'b0 || bus.WrEn !== 1'b0 || bus.Busy !== 1'b0) begin
                errors++;
                $display("FAIL midclear_quiet c%0d: ClearDone=%b WrEn=%b Busy=%b expected 0/0/0",
                         c, bus.ClearDone, bus.WrEn, bus.Busy);
            end
        end
        tick();
        setReq(1, 5'd7, 32'h0000_0055);
        bus.ReqValid = 3'b010;
        #2;
        checks++;
        if (bus.ReqReady !== 3'b010) begin
            errors++;
            $display("FAIL midclear_grant: ReqReady=%b expected 010", bus.ReqReady);
        end
        tick();
        bus.ReqValid = 3'b000;
        #2;
        checks++;
        if (bus.WrEn !== 1'b1 || bus.WrAddr !== 5'd7 || bus.WrData !== 32'h0000_0055) begin
            errors++;
            $display("FAIL midclear_write: WrEn=%b WrAddr=%0d WrData=%h expected 1/7/55",
                     bus.WrEn, bus.WrAddr, bus.WrData);
        end
        expPtr = 2;
    endtask

    // rrPtr starts at 2: req2 is idle, so the search wraps to req0 first.
    task automatic test_back_to_back();
        logic [2:0] vecValid [3];
        logic [2:0] vecGrant [3];
        logic [4:0] vecAddr  [3];
        vecValid = '{3'b011, 3'b110, 3'b100};
        vecGrant = '{3'b001, 3'b010, 3'b100};
        vecAddr  = '{5'd11, 5'd12, 5'd13};
        setReq(0, 5'd11, 32'h0000_00B0);
        setReq(1, 5'd12, 32'h0000_00B1);
        setReq(2, 5'd13, 32'h0000_00B2);
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.ReqValid = (c < 3) ? vecValid[c] : 3'b000;
            #2;
            if (c > 0) begin
                checks++;
                if (bus.WrEn !== 1'b1 || bus.WrAddr !== vecAddr[c-1]) begin
                    errors++;
                    $display("FAIL b2b_write c%0d: WrEn=%b WrAddr=%0d expected 1/%0d",
                             c, bus.WrEn, bus.WrAddr, vecAddr[c-1]);
                end
            end
            if (c < 3) begin
                checks++;
                if (bus.ReqReady !== vecGrant[c]) begin
                    errors++;
                    $display("FAIL b2b_grant c%0d: ReqReady=%b expected %b", c, bus.ReqReady, vecGrant[c]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        expPtr = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_clear_with_req();
        test_protect_r0();
        test_reset_mid_clear();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the single write port (data, destination address, enable) of the 32x32 register file. Grants the port round-robin among NREQ requesters over a valid/ready handshake, and runs a clear sequence that writes zero to all 32 registers. Sits directly in front of the register file write port. Read ports are not touched.

## Interface

**Parameters**
- NREQ, 3: number of write requesters (legal 2..8).
- PROTECT_R0, 1: when 1, requester writes to address 0 are accepted but dropped (WrEn stays 0).

**Ports**
- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid  in  NREQ  requester i has a write pending.
- ReqReady  out  NREQ  one-hot grant; combinational from state, valids and RR pointer.
- ReqAddr  in  NREQ*5  requester i address at [5i+4:5i].
- ReqData  in  NREQ*32  requester i data at [32i+31:32i].
- ClearStart  in  1  single-cycle request to zero all registers.
- Busy  out  1  high while in CLEAR.
- ClearDone  out  1  one-cycle pulse after the last clear write is issued.
- WrData  out  32  to register file D.
- WrAddr  out  5  to register file DA.
- WrEn  out  1  to register file En.

## Operation

- FSM states IDLE and CLEAR; reset state is IDLE.
- **IDLE**
  - If ClearStart=1: go to CLEAR, load clear counter to 0, all ReqReady=0 this cycle. Clear beats requests arriving in the same cycle.
  - Otherwise, if any ReqValid: grant exactly one requester, the first valid at or after rr_ptr, wrapping modulo NREQ.
  - ReqReady[g]=1; the transfer completes this cycle since valid&ready.
  - rr_ptr becomes (g+1) mod NREQ.
  - WrAddr/WrData register the granted requester's fields; WrEn=1, or 0 if PROTECT_R0=1 and the address is 0.
  - No valid: WrEn=0; WrAddr/WrData hold their previous values.
- **CLEAR**
  - Each cycle: WrEn=1, WrAddr=counter, WrData=0, counter+1. Address 0 is included regardless of PROTECT_R0.
  - When counter=31 is issued: return to IDLE next cycle and pulse ClearDone in that cycle.
  - ReqReady=0 throughout. ClearStart is ignored while in CLEAR.
- Requester rules:
  - ReqValid may not drop, and fields may not change, until the handshake completes.
  - Unselected requesters wait; rr_ptr guarantees service within NREQ grants.
- Counter is 5 bits and wraps 31->0 only at exit. rr_ptr width is clog2(NREQ); it never holds a value >= NREQ.

## Timing

- Reset values: WrEn=0, WrAddr=0, WrData=0, Busy=0, ClearDone=0, rr_ptr=0, counter=0, state IDLE. ReqReady=0 while Reset is low.
- Write latency:
  - Handshake in cycle t gives WrEn/WrAddr/WrData valid in cycle t+1.
  - The register file captures at the end of t+1.
  - The value is readable on A/B in t+2.
- Throughput: one write per cycle, back-to-back, across any mix of requesters.
- Clear:
  - ClearStart in cycle t gives Busy=1 in t+1..t+32 and write addresses 0..31 in t+1..t+32.
  - ClearDone=1 and Busy=0 in t+33; requests can be granted in t+33.
- Reset asserted mid-clear: immediate return to reset values. The clear is not resumed, and no ClearDone is issued.
- ClearStart and a last-beat request in the same IDLE cycle: the request is not granted; it is served after ClearDone.

## Structure

- Package regwr_pkg holds:
  - ADDR_W=5, DATA_W=32, NREG=32.
  - State enum {IDLE, CLEAR}.
  - CLEAR_LAST=NREG-1.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; output one-hot grant[N] plus the encoded index. Purely combinational.
- Top level holds the FSM, clear counter, rr_ptr, and output registers.

## Test plan

- Reset release, no activity -> WrEn=0, WrAddr=0, WrData=0, ReqReady=0 for 10 cycles.
- Req0 alone (addr 5, data 0xDEADBEEF) -> ReqReady[0]=1 same cycle; next cycle WrEn=1, WrAddr=5, WrData=0xDEADBEEF; register file reads 0xDEADBEEF on A with SA=5 one cycle later.
- All three valid continuously with addresses 1/2/3 -> grants in order 0,1,2,0,1,2, one per cycle; WrAddr sequence 1,2,3,1,2,3 with no bubbles.
- PROTECT_R0=1, req1 writes addr 0 data 0x1234 -> ReqReady[1]=1, WrEn stays 0, R0 unchanged.
- ClearStart with req2 valid in the same cycle -> 32 cycles WrEn=1, addresses 0..31, data 0; ReqReady=0 throughout; ClearDone pulse on cycle 33; req2 granted that cycle; all registers read 0 except req2's target.
- Reset asserted at clear beat 10 -> outputs return to reset values immediately; no ClearDone; after release the FSM is in IDLE and grants requests normally.
